// File: rtl/motor_pulse_generator.sv
// Stepper driver pulse generator: turns a change-bit toggle into a move of
// step_count STEP pulses, with DIR set up ahead of the first pulse and one
// queued request for toggles that arrive while a move is in progress.
module motor_pulse_generator #(
  parameter int DIR_SETUP   = 2,
  parameter int HIGH_CYCLES = 3,
  parameter int LOW_CYCLES  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] step_count,
  input  logic        dir_in,
  input  logic        change,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        done,
  output logic [10:0] steps_remaining
);

  localparam int MAX_PH = (DIR_SETUP > HIGH_CYCLES) ?
                          ((DIR_SETUP > LOW_CYCLES) ? DIR_SETUP : LOW_CYCLES) :
                          ((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES);
  localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(DIR_SETUP - 1);
  localparam logic [PH_W-1:0] HIGH_LAST  = PH_W'(HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0] LOW_LAST   = PH_W'(LOW_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q;
  logic            phase_last;
  logic            change_q;
  logic            toggle;
  logic            pend_q;
  logic [10:0]     pend_cnt_q;
  logic            pend_dir_q;
  logic            load;
  logic [10:0]     load_cnt;
  logic            load_dir;
  logic            step_d, busy_d, done_d;

  assign toggle = change ^ change_q;

  // A queued request always wins over the live inputs when a move is started;
  // IDLE also starts on a pending request left over from a toggle in DONE.
  assign load     = ((state_q == IDLE) && (toggle || pend_q)) ||
                    ((state_q == DONE) && pend_q);
  assign load_cnt = pend_q ? pend_cnt_q : step_count;
  assign load_dir = pend_q ? pend_dir_q : dir_in;

  // Marks the final cycle of the current timed phase
  always_comb begin
    phase_last = 1'b0;
    case (state_q)
      SETUP:   phase_last = (phase_q == SETUP_LAST);
      HIGH:    phase_last = (phase_q == HIGH_LAST);
      LOW:     phase_last = (phase_q == LOW_LAST);
      default: phase_last = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SETUP;
      SETUP:   if (phase_last) state_d = (steps_remaining == 11'd0) ? DONE : HIGH;
      HIGH:    if (phase_last) state_d = LOW;
      LOW:     if (phase_last) state_d = (steps_remaining != 11'd0) ? HIGH : DONE;
      DONE:    state_d = load ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so step/busy/done come straight off flops
  always_comb begin
    step_d = (state_d == HIGH);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State, phase timer, move datapath and pending slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      phase_q         <= '0;
      change_q        <= change;
      pend_q          <= 1'b0;
      step            <= 1'b0;
      dir             <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      steps_remaining <= 11'd0;
    end else begin
      state_q  <= state_d;
      change_q <= change;
      step     <= step_d;
      busy     <= busy_d;
      done     <= done_d;

      if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE))
        phase_q <= '0;
      else
        phase_q <= phase_q + 1'b1;

      if (load) begin
        dir             <= load_dir;
        steps_remaining <= load_cnt;
      end else if ((state_q == HIGH) && phase_last) begin
        steps_remaining <= steps_remaining - 11'd1;
      end

      // Latest toggle seen while busy (or while a queued request is being
      // consumed) overwrites the slot; otherwise a consumed slot is freed.
      if (toggle && ((state_q != IDLE) || pend_q)) begin
        pend_q     <= 1'b1;
        pend_cnt_q <= step_count;
        pend_dir_q <= dir_in;
      end else if (load && pend_q) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_motor_pulse_generator.sv
// Directed bench for motor_pulse_generator with default timing (2/3/5).
module tb_motor_pulse_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] step_count;
  logic        dir_in;
  logic        change;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic [10:0] steps_remaining;

  int tests = 0;
  int fails = 0;
  int rises = 0;
  int dones = 0;
  logic prev_step = 1'b0;
  logic busy_seen = 1'b0;

  motor_pulse_generator #(.DIR_SETUP(2), .HIGH_CYCLES(3), .LOW_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .step_count(step_count), .dir_in(dir_in),
    .change(change), .step(step), .dir(dir), .busy(busy), .done(done),
    .steps_remaining(steps_remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (step && !prev_step) rises++;
    prev_step = step;
    if (done) dones++;
    if (busy) busy_seen = 1'b1;
  endtask

  initial begin
    int r0, r1, d0;
    logic exp_step;
    logic finished;

    // Reset with change held high: no spurious move
    reset = 1'b1; change = 1'b1; step_count = 11'd0; dir_in = 1'b0;
    tick();
    tick();
    chk("rst_step", step, 1'b0);
    chk("rst_dir", dir, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sr", steps_remaining, 11'd0);
    reset = 1'b0;
    r0 = rises; busy_seen = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("hold_rises", rises - r0, 0);
    chk("hold_busy", busy_seen, 1'b0);

    // Three-pulse move, dir=1
    step_count = 11'd3; dir_in = 1'b1; change = ~change;
    r0 = rises;
    tick();
    chk("m3_dir", dir, 1'b1);
    chk("m3_busy", busy, 1'b1);
    chk("m3_sr0", steps_remaining, 11'd3);
    chk("m3_step0", step, 1'b0);
    for (int k = 1; k <= 27; k++) begin
      tick();
      exp_step = (k >= 2) && (((k - 2) % 8) < 3) && (((k - 2) / 8) < 3);
      chk($sformatf("m3_step_c%0d", k), step, exp_step);
      chk($sformatf("m3_done_c%0d", k), done, k == 26);
      if (k == 4)  chk("m3_sr_c4", steps_remaining, 11'd3);
      if (k == 5)  chk("m3_sr_c5", steps_remaining, 11'd2);
      if (k == 13) chk("m3_sr_c13", steps_remaining, 11'd1);
      if (k == 21) chk("m3_sr_c21", steps_remaining, 11'd0);
      if (k == 26) chk("m3_busy_done", busy, 1'b1);
      if (k == 27) chk("m3_busy_end", busy, 1'b0);
    end
    chk("m3_rises", rises - r0, 3);

    // Zero-count move
    step_count = 11'd0; change = ~change;
    r0 = rises;
    tick();
    chk("m0_busy", busy, 1'b1);
    chk("m0_sr", steps_remaining, 11'd0);
    tick();
    chk("m0_done_c1", done, 1'b0);
    tick();
    chk("m0_done_c2", done, 1'b1);
    tick();
    chk("m0_busy_c3", busy, 1'b0);
    chk("m0_rises", rises - r0, 0);

    // Move of 4 with dir=0; two requests while busy, only the latest runs
    step_count = 11'd4; dir_in = 1'b0; change = ~change;
    r0 = rises;
    tick();
    chk("q_dir0", dir, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      if (k == 5) begin step_count = 11'd2; dir_in = 1'b1; change = ~change; end
      if (k == 7) begin step_count = 11'd5; change = ~change; end
      tick();
      if (dir !== 1'b0) chk($sformatf("q_dir_c%0d", k), dir, 1'b0);
      if (k >= 30) chk($sformatf("q_done_c%0d", k), done, k == 34);
    end
    chk("q_rises1", rises - r0, 4);
    tick();
    chk("q_reload_busy", busy, 1'b1);
    chk("q_reload_dir", dir, 1'b1);
    chk("q_reload_sr", steps_remaining, 11'd5);
    chk("q_reload_done", done, 1'b0);
    r1 = rises; d0 = dones;
    for (int k = 36; k <= 77; k++) tick();
    chk("q_done2", done, 1'b1);
    chk("q_done2_once", dones - d0, 1);
    chk("q_rises2", rises - r1, 5);
    tick();
    chk("q_idle", busy, 1'b0);

    // Reset in the middle of a 100-pulse move
    step_count = 11'd100; dir_in = 1'b1; change = ~change;
    tick();
    for (int k = 1; k <= 39; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_step", step, 1'b0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_sr", steps_remaining, 11'd0);
    r0 = rises; d0 = dones; busy_seen = 1'b0;
    for (int i = 0; i < 900; i++) tick();
    chk("rm_rises", rises - r0, 0);
    chk("rm_dones", dones - d0, 0);
    chk("rm_busy_after", busy_seen, 1'b0);

    // Maximum count
    step_count = 11'd2047; dir_in = 1'b0; change = ~change;
    r0 = rises; d0 = dones; finished = 1'b0;
    tick();
    chk("max_sr0", steps_remaining, 11'd2047);
    for (int i = 0; i < 2 + 2047 * 8 + 20; i++) begin
      tick();
      if (!busy) begin finished = 1'b1; break; end
    end
    chk("max_finished", finished, 1'b1);
    chk("max_rises", rises - r0, 2047);
    chk("max_dones", dones - d0, 1);
    chk("max_sr_end", steps_remaining, 11'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
